// File: rtl/edge_event_arbiter.sv
// Edge-event scheduler: per-channel edge capture, one pending event per channel,
// round-robin drain onto a single valid/ready port. Optional macro: EDGE_ARB_SYNC_EN.
module edge_event_arbiter #(
  parameter int N = 4,
  localparam int CW = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  din,
  input  logic [N-1:0]  en_mask,
  input  logic [1:0]    edge_sel,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [CW-1:0] evt_ch,
  output logic          evt_rise,
  output logic [N-1:0]  ovf,
  input  logic          ovf_clr
);

  // Handshake: an event transfers on a rising clk edge where evt_valid & evt_ready;
  // while evt_valid & ~evt_ready, evt_ch/evt_rise hold and no new grant is made.

  logic [N-1:0]  d;
  logic [N-1:0]  prev;
  logic [N-1:0]  pend;
  logic [N-1:0]  pend_dir;
  logic [CW-1:0] rr;

`ifdef EDGE_ARB_SYNC_EN
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  assign d = sync2;
`else
  assign d = din;
`endif

  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] qual;

  assign rise = ~prev & d;
  assign fall = prev & ~d;
  assign qual = en_mask & ((rise & {N{edge_sel[0]}}) | (fall & {N{edge_sel[1]}}));

  // Round-robin search starting at rr, wrapping N-1 -> 0.
  logic          any_pend;
  logic [CW-1:0] winner;

  always_comb begin
    int j;
    any_pend = 1'b0;
    winner   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr) + k;
      if (j >= N) j = j - N;
      if (!any_pend && pend[j]) begin
        any_pend = 1'b1;
        winner   = CW'(j);
      end
    end
  end

  logic          load;
  logic          grant;
  logic [N-1:0]  grant_vec;
  logic [CW-1:0] rr_next;

  assign load  = ~evt_valid | evt_ready;
  assign grant = load & any_pend;

  always_comb begin
    grant_vec = '0;
    if (grant) grant_vec[winner] = 1'b1;
    if (int'(winner) == N - 1) rr_next = '0;
    else                       rr_next = winner + CW'(1);
  end

  logic [N-1:0] pend_nxt;
  logic [N-1:0] dir_nxt;
  logic [N-1:0] ovf_set;

  // A granted channel may re-arm in the same cycle; otherwise a second edge overflows.
  always_comb begin
    pend_nxt = pend;
    dir_nxt  = pend_dir;
    ovf_set  = '0;
    for (int i = 0; i < N; i++) begin
      if (qual[i]) begin
        if (pend[i] && !grant_vec[i]) begin
          ovf_set[i] = 1'b1;
        end else begin
          pend_nxt[i] = 1'b1;
          dir_nxt[i]  = rise[i];
        end
      end else if (grant_vec[i]) begin
        pend_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= '0;
      pend     <= '0;
      pend_dir <= '0;
      ovf      <= '0;
    end else begin
      prev     <= d;
      pend     <= pend_nxt;
      pend_dir <= dir_nxt;
      ovf      <= (ovf & ~{N{ovf_clr}}) | ovf_set;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
      rr        <= '0;
    end else if (grant) begin
      evt_valid <= 1'b1;
      evt_ch    <= winner;
      evt_rise  <= pend_dir[winner];
      rr        <= rr_next;
    end else if (load) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=4, default build): hand-computed
// expected events, ovf behaviour, masking and asynchronous reset.
module tb_edge_event_arbiter;

  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  din;
  logic [N-1:0]  en_mask;
  logic [1:0]    edge_sel;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_ch;
  logic          evt_rise;
  logic [N-1:0]  ovf;
  logic          ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_q[$];

  edge_event_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .en_mask   (en_mask),
    .edge_sel  (edge_sel),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    din = '0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0; din = '0; en_mask = 4'hf; edge_sel = 2'b01;
    evt_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) step();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_ch",    32'(evt_ch),    32'd0);
    check("rst_rise",  32'(evt_rise),  32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    rst = 1'b1;
    step();

    // single rising event on ch0, 2-cycle latency, one cycle wide
    din = 4'b0001;
    step();
    check("t1_lat1", 32'(evt_valid), 32'd0);
    step();
    check("t1_valid", 32'(evt_valid), 32'd1);
    check("t1_ch",    32'(evt_ch),    32'd0);
    check("t1_rise",  32'(evt_rise),  32'd1);
    step();
    check("t1_single", 32'(evt_valid), 32'd0);

    // falling-only select on ch2
    edge_sel = 2'b10;
    din = 4'b0101;
    step(); step();
    check("t2_norise", 32'(evt_valid), 32'd0);
    din = 4'b0001;
    step();
    check("t2_lat1", 32'(evt_valid), 32'd0);
    step();
    check("t2_valid", 32'(evt_valid), 32'd1);
    check("t2_ch",    32'(evt_ch),    32'd2);
    check("t2_rise",  32'(evt_rise),  32'd0);
    step();
    check("t2_single", 32'(evt_valid), 32'd0);

    // simultaneous burst on ch0,1,3 from rr=0, then pointer wrap check
    do_reset();
    edge_sel = 2'b01;
    din = 4'b1011;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    step();
    check("t3_lat1", 32'(evt_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_valid", 32'(evt_valid), 32'd1);
      check("t3_ch", 32'(evt_ch), 32'(exp_q.pop_front()));
    end
    step();
    check("t3_drained", 32'(evt_valid), 32'd0);
    din = 4'b0000;
    step(); step();
    check("t3_nofall", 32'(evt_valid), 32'd0);
    din = 4'b1001;
    step(); step();
    check("t3_wrap_ch0", 32'(evt_ch), 32'd0);
    step();
    check("t3_wrap_ch3", 32'(evt_ch), 32'd3);
    step();
    check("t3_wrap_end", 32'(evt_valid), 32'd0);

    // backpressure, pending, overflow and ovf_clr on ch1
    edge_sel = 2'b11;
    evt_ready = 1'b0;
    din = 4'b1011;
    step();
    check("t4_lat1", 32'(evt_valid), 32'd0);
    step();
    check("t4_valid", 32'(evt_valid), 32'd1);
    check("t4_ch",    32'(evt_ch),    32'd1);
    check("t4_rise",  32'(evt_rise),  32'd1);
    din = 4'b1001;
    step();
    check("t4_hold_ch",   32'(evt_ch),   32'd1);
    check("t4_hold_rise", 32'(evt_rise), 32'd1);
    check("t4_no_ovf",    32'(ovf),      32'd0);
    din = 4'b1011;
    step();
    check("t4_ovf",       32'(ovf),       32'h2);
    check("t4_hold2",     32'(evt_valid), 32'd1);
    check("t4_hold2_rise", 32'(evt_rise), 32'd1);
    evt_ready = 1'b1;
    step();
    check("t4_next_valid", 32'(evt_valid), 32'd1);
    check("t4_next_ch",    32'(evt_ch),    32'd1);
    check("t4_next_rise",  32'(evt_rise),  32'd0);
    step();
    check("t4_drained",  32'(evt_valid), 32'd0);
    check("t4_ovf_stky", 32'(ovf),       32'h2);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(ovf), 32'd0);

    // mask ch2: pending event still drains, later edges ignored
    din = 4'b1111;
    step();
    en_mask = 4'b1011;
    din = 4'b1011;
    step();
    check("t5_valid", 32'(evt_valid), 32'd1);
    check("t5_ch",    32'(evt_ch),    32'd2);
    check("t5_rise",  32'(evt_rise),  32'd1);
    din = 4'b1111;
    step();
    check("t5_drained", 32'(evt_valid), 32'd0);
    din = 4'b1011;
    step();
    din = 4'b1111;
    step(); step();
    check("t5_masked", 32'(evt_valid), 32'd0);
    check("t5_ovf",    32'(ovf),       32'd0);
    en_mask = 4'hf;

    // async reset while presenting with ch0/ch3 pending
    evt_ready = 1'b0;
    din = 4'b1101;
    step(); step();
    check("t6_valid", 32'(evt_valid), 32'd1);
    check("t6_ch",    32'(evt_ch),    32'd1);
    din = 4'b0100;
    step();
    check("t6_pre_rst", 32'(evt_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", 32'(evt_valid), 32'd0);
    check("t6_rst_ch",    32'(evt_ch),    32'd0);
    check("t6_rst_rise",  32'(evt_rise),  32'd0);
    check("t6_rst_ovf",   32'(ovf),       32'd0);
    din = 4'b0000;
    step();
    rst = 1'b1;
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t6_quiet", 32'(evt_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
